instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_pkg.sv | 38 +++
 rtl/instr_encoder_if.sv | 26 ++
 rtl/instr_enc_fifo.sv | 54 +++++
 rtl/instr_encoder.sv | 107 ++++++++++
 tb/tb_instr_encoder.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_encoder_pkg.sv
// rtl/instr_encoder_pkg.sv - shared state enum, field layout and word packing; parity under INSTR_ENCODER_PARITY_EN
package instr_encoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } enc_state_t;

    localparam int IDEN_W     = 2;
    localparam int OPCODE_W   = 4;
    localparam int ADDR_W     = 8;
    localparam int WORD_W     = 16;

    localparam int IDEN_LSB   = 12;
    localparam int OPCODE_LSB = 8;
    localparam int ADDR_LSB   = 0;
    localparam int PARITY_BIT = 15;

    // Builds the memory word; bits [15:14] stay zero unless parity is enabled,
    // in which case bit 15 makes the total number of ones even.
    function automatic logic [WORD_W-1:0] pack_word(
        input logic [IDEN_W-1:0]   iden,
        input logic [OPCODE_W-1:0] opcode,
        input logic [ADDR_W-1:0]   address
    );
        logic [WORD_W-1:0] w;
        w = '0;
        w[IDEN_LSB +: IDEN_W]     = iden;
        w[OPCODE_LSB +: OPCODE_W] = opcode;
        w[ADDR_LSB +: ADDR_W]     = address;
`ifdef INSTR_ENCODER_PARITY_EN
        w[PARITY_BIT] = ^w[PARITY_BIT-1:0];
`endif
        return w;
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - instruction field handshake and memory write bus
interface instr_encoder_if;
    import instr_encoder_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [IDEN_W-1:0]   in_iden;
    logic [OPCODE_W-1:0] in_opcode;
    logic [ADDR_W-1:0]   in_address;
    logic                in_last;

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [WORD_W-1:0]   mem_wdata;
    logic                mem_ready;

    modport master (
        output in_valid, in_iden, in_opcode, in_address, in_last, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_iden, in_opcode, in_address, in_last, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_enc_fifo.sv
// rtl/instr_enc_fifo.sv - occupancy-counted FIFO holding packed words plus last flag
module instr_enc_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == (PTR_W+1)'(DEPTH));
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = store[rd_ptr];

    // Pointer and occupancy tracking; a push and pop together leave count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // Word storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - packs instruction fields and streams them into instruction memory; INSTR_ENCODER_PARITY_EN adds parity bit
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 8'h00
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    instr_encoder_if.slave  bus,
    output logic            busy,
    output logic            done,
    output logic            overflow
);
    enc_state_t        state;
    enc_state_t        state_nxt;
    logic [ADDR_W-1:0] wr_ptr;
    logic              wrap;
    logic              last_seen;
    logic              session_start;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic              fifo_full;
    logic [WORD_W:0]   head;
    logic              head_last;
    logic [WORD_W-1:0] head_word;

    assign session_start = (state == ST_IDLE) && start;
    assign push          = bus.in_valid && bus.in_ready;
    assign head_last     = head[WORD_W];
    assign head_word     = head[WORD_W-1:0];
    assign bus.mem_addr  = wr_ptr;
    assign bus.mem_wdata = fifo_empty ? '0 : head_word;

    instr_enc_fifo #(
        .WIDTH (WORD_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (session_start),
        .push      (push),
        .push_data ({bus.in_last, pack_word(bus.in_iden, bus.in_opcode, bus.in_address)}),
        .pop       (pop),
        .head_data (head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Session state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state and handshake outputs; after wrap the head is discarded instead of written.
    always_comb begin
        state_nxt    = state;
        busy         = 1'b0;
        done         = 1'b0;
        bus.in_ready = 1'b0;
        bus.mem_we   = 1'b0;
        pop          = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                busy         = 1'b1;
                bus.in_ready = !fifo_full && !last_seen;
                bus.mem_we   = !fifo_empty && !wrap;
                pop          = !fifo_empty && (wrap || bus.mem_ready);
                if (pop && head_last) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Write pointer, wrap/overflow flags and last-accepted tracking per session.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= BASE_ADDR;
            wrap      <= 1'b0;
            overflow  <= 1'b0;
            last_seen <= 1'b0;
        end else if (session_start) begin
            wr_ptr    <= BASE_ADDR;
            wrap      <= 1'b0;
            overflow  <= 1'b0;
            last_seen <= 1'b0;
        end else begin
            if (push && bus.in_last) last_seen <= 1'b1;
            if (pop) begin
                if (wrap)               overflow <= 1'b1;
                else if (wr_ptr == '1)  wrap     <= 1'b1;
                else                    wr_ptr   <= wr_ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - scoreboard bench for instr_encoder (optionally with INSTR_ENCODER_PARITY_EN)
module tb_instr_encoder;

`ifdef INSTR_ENCODER_PARITY_EN
    localparam logic [15:0] WORD_01_3_A5 = 16'h93A5;
`else
    localparam logic [15:0] WORD_01_3_A5 = 16'h13A5;
`endif

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start0, start1;
    logic busy0, done0, ovf0;
    logic busy1, done1, ovf1;

    instr_encoder_if bus0 ();
    instr_encoder_if bus1 ();

    instr_encoder #(.FIFO_DEPTH(4), .BASE_ADDR(8'h00)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .bus(bus0),
        .busy(busy0), .done(done0), .overflow(ovf0)
    );

    instr_encoder #(.FIFO_DEPTH(4), .BASE_ADDR(8'hFE)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .bus(bus1),
        .busy(busy1), .done(done1), .overflow(ovf1)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    bit   toggle_en = 1'b0;
    wr_t  q0[$];
    wr_t  q1[$];
    logic [7:0] exp_addr [2];
    bit   exp_wrap [2];
    bit   exp_ovf [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_word(input logic [1:0] iden, input logic [3:0] op, input logic [7:0] a);
        logic [15:0] w;
        w = {2'b00, iden, op, a};
`ifdef INSTR_ENCODER_PARITY_EN
        w[15] = ^w[14:0];
`endif
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (toggle_en) bus0.mem_ready = ~bus0.mem_ready;
    endtask

    task automatic drive_fields(input int sel, input logic [1:0] iden, input logic [3:0] op,
                                input logic [7:0] a, input logic last, input logic valid);
        if (sel == 0) begin
            bus0.in_iden = iden; bus0.in_opcode = op; bus0.in_address = a;
            bus0.in_last = last; bus0.in_valid = valid;
        end else begin
            bus1.in_iden = iden; bus1.in_opcode = op; bus1.in_address = a;
            bus1.in_last = last; bus1.in_valid = valid;
        end
    endtask

    task automatic model_push(input int sel, input logic [15:0] w);
        wr_t e;
        if (!exp_wrap[sel]) begin
            e.addr = exp_addr[sel];
            e.data = w;
            if (sel == 0) q0.push_back(e);
            else          q1.push_back(e);
            if (exp_addr[sel] == 8'hFF) exp_wrap[sel] = 1'b1;
            else                        exp_addr[sel] = exp_addr[sel] + 8'd1;
        end else begin
            exp_ovf[sel] = 1'b1;
        end
    endtask

    task automatic accept(input int sel, input logic [1:0] iden, input logic [3:0] op,
                          input logic [7:0] a, input logic last);
        bit   ok;
        logic rdy;
        ok = 1'b0;
        drive_fields(sel, iden, op, a, last, 1'b1);
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            rdy = (sel == 0) ? bus0.in_ready : bus1.in_ready;
            if (rdy) begin
                ok = 1'b1;
                model_push(sel, exp_word(iden, op, a));
            end
            step();
        end
        drive_fields(sel, iden, op, a, last, 1'b0);
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic start_session(input int sel, input logic [7:0] base);
        if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
        exp_addr[sel] = base;
        exp_wrap[sel] = 1'b0;
        exp_ovf[sel]  = 1'b0;
        step();
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done(input int sel);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if ((sel == 0) ? done0 : done1) seen = 1'b1;
            else step();
        end
        check("done_seen", 32'(seen), 32'd1);
        check("busy_in_done", 32'((sel == 0) ? busy0 : busy1), 32'd0);
        check("overflow", 32'((sel == 0) ? ovf0 : ovf1), 32'(exp_ovf[sel]));
        check("sb_drained", 32'((sel == 0) ? q0.size() : q1.size()), 32'd0);
        step();
        @(negedge clk);
        check("done_once", 32'((sel == 0) ? done0 : done1), 32'd0);
        step();
    endtask

    logic        stall0_q = 1'b0;
    logic [7:0]  st_addr0;
    logic [15:0] st_data0;

    // Scoreboard and stall-hold monitor for the BASE_ADDR=00 instance.
    always @(negedge clk) begin
        wr_t e;
        if (bus0.mem_we && stall0_q) begin
            check("hold_addr", 32'(bus0.mem_addr), 32'(st_addr0));
            check("hold_data", 32'(bus0.mem_wdata), 32'(st_data0));
        end
        if (bus0.mem_we && bus0.mem_ready) begin
            if (q0.size() == 0) check("write_unexpected0", 32'd1, 32'd0);
            else begin
                e = q0.pop_front();
                check("wr_addr0", 32'(bus0.mem_addr), 32'(e.addr));
                check("wr_data0", 32'(bus0.mem_wdata), 32'(e.data));
            end
        end
        stall0_q = bus0.mem_we && !bus0.mem_ready;
        st_addr0 = bus0.mem_addr;
        st_data0 = bus0.mem_wdata;
    end

    // Scoreboard monitor for the BASE_ADDR=FE instance.
    always @(negedge clk) begin
        wr_t e;
        if (bus1.mem_we && bus1.mem_ready) begin
            if (q1.size() == 0) check("write_unexpected1", 32'd1, 32'd0);
            else begin
                e = q1.pop_front();
                check("wr_addr1", 32'(bus1.mem_addr), 32'(e.addr));
                check("wr_data1", 32'(bus1.mem_wdata), 32'(e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        drive_fields(0, 2'b00, 4'h0, 8'h00, 1'b0, 1'b0);
        drive_fields(1, 2'b00, 4'h0, 8'h00, 1'b0, 1'b0);
        bus0.mem_ready = 1'b0;
        bus1.mem_ready = 1'b0;

        // Reset state
        @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(bus0.in_ready), 32'd0);
        check("rst_mem_we", 32'(bus0.mem_we), 32'd0);
        check("rst_mem_addr", 32'(bus0.mem_addr), 32'h00);
        check("rst_mem_wdata", 32'(bus0.mem_wdata), 32'h0000);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_overflow", 32'(ovf0), 32'd0);
        check("rst_mem_addr_fe", 32'(bus1.mem_addr), 32'hFE);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // Single word, memory always ready
        bus0.mem_ready = 1'b1;
        start_session(0, 8'h00);
        @(negedge clk);
        check("load_busy", 32'(busy0), 32'd1);
        check("load_in_ready", 32'(bus0.in_ready), 32'd1);
        step();
        accept(0, 2'b01, 4'h3, 8'hA5, 1'b1);
        @(negedge clk);
        check("single_we", 32'(bus0.mem_we), 32'd1);
        check("single_addr", 32'(bus0.mem_addr), 32'h00);
        check("single_word", 32'(bus0.mem_wdata), 32'(WORD_01_3_A5));
        check("ready_after_last", 32'(bus0.in_ready), 32'd0);
        step();
        @(negedge clk);
        check("single_done", 32'(done0), 32'd1);
        check("single_busy", 32'(busy0), 32'd0);
        step();
        @(negedge clk);
        check("single_done_clear", 32'(done0), 32'd0);
        check("single_idle_busy", 32'(busy0), 32'd0);
        step();

        // Back-to-back fill with memory stalled; start in LOAD must be ignored
        bus0.mem_ready = 1'b0;
        start_session(0, 8'h00);
        for (int i = 0; i < 4; i++)
            accept(0, 2'(i), 4'(i + 4), 8'(8'h10 + i), 1'b0);
        drive_fields(0, 2'b11, 4'hF, 8'h55, 1'b1, 1'b1);
        @(negedge clk);
        check("full_in_ready", 32'(bus0.in_ready), 32'd0);
        check("full_mem_we", 32'(bus0.mem_we), 32'd1);
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        step();
        bus0.mem_ready = 1'b1;
        accept(0, 2'b11, 4'hF, 8'h55, 1'b1);
        wait_done(0);

        // Memory ready toggling every cycle
        bus0.mem_ready = 1'b0;
        toggle_en = 1'b1;
        start_session(0, 8'h00);
        for (int i = 0; i < 6; i++)
            accept(0, 2'(3 - (i % 4)), 4'(15 - i), 8'(8'hC0 + 3 * i), (i == 5));
        wait_done(0);
        toggle_en = 1'b0;

        // Asynchronous reset in the middle of a session
        bus0.mem_ready = 1'b0;
        start_session(0, 8'h00);
        accept(0, 2'b10, 4'h1, 8'h11, 1'b0);
        accept(0, 2'b01, 4'h2, 8'h22, 1'b0);
        #2;
        check("pre_reset_we", 32'(bus0.mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_mem_we", 32'(bus0.mem_we), 32'd0);
        check("arst_in_ready", 32'(bus0.in_ready), 32'd0);
        check("arst_busy", 32'(busy0), 32'd0);
        check("arst_mem_addr", 32'(bus0.mem_addr), 32'h00);
        check("arst_mem_wdata", 32'(bus0.mem_wdata), 32'h0000);
        q0.delete();
        step();
        rst_n = 1'b1;
        step();
        bus0.mem_ready = 1'b1;
        start_session(0, 8'h00);
        accept(0, 2'b10, 4'h7, 8'h3C, 1'b1);
        wait_done(0);

        // Address space exhaustion from BASE_ADDR=FE
        bus1.mem_ready = 1'b1;
        start_session(1, 8'hFE);
        accept(1, 2'b01, 4'h3, 8'hA5, 1'b0);
        accept(1, 2'b10, 4'h4, 8'h5A, 1'b0);
        accept(1, 2'b11, 4'h5, 8'h0F, 1'b1);
        wait_done(1);
        @(negedge clk);
        check("overflow_sticky", 32'(ovf1), 32'd1);
        step();
        start_session(1, 8'hFE);
        @(negedge clk);
        check("overflow_cleared", 32'(ovf1), 32'd0);
        check("restart_addr", 32'(bus1.mem_addr), 32'hFE);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
